// File: rtl/demux_stream.sv
// demux_stream: 1-to-2 valid/ready stream demultiplexer.
// Each accepted input word is steered by sel into a one-word output register
// for channel 0 or 1. Each channel also counts the words delivered to it, and
// that count wraps silently. A full channel only stalls words aimed at it, so
// the other channel keeps flowing (no head-of-line blocking).
module demux_stream #(
  parameter int N  = 8,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          sel,
  input  logic [N-1:0]  d,
  input  logic          d_valid,
  output logic          d_ready,
  output logic [N-1:0]  q0,
  output logic          q0_valid,
  input  logic          q0_ready,
  output logic [N-1:0]  q1,
  output logic          q1_valid,
  input  logic          q1_ready,
  output logic [CW-1:0] cnt0,
  output logic [CW-1:0] cnt1
);

  // Per-channel views of the consumer handshake and the slot state.
  logic [1:0] ready_w;
  logic [1:0] valid_w;
  logic [1:0] free_w;
  logic [1:0] load_w;
  logic       accept_w;

  assign ready_w = {q1_ready, q0_ready};

  // A channel can take a word if it is empty or is being drained this cycle.
  // Reset gates d_ready so that no word is accepted while state is cleared.
  assign d_ready  = ~reset & (sel ? free_w[1] : free_w[0]);
  assign accept_w = d_valid & d_ready;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_ch
      logic [N-1:0]  q_reg,     q_next;
      logic          valid_reg, valid_next;
      logic [CW-1:0] cnt_reg,   cnt_next;

      assign valid_w[gi] = valid_reg;
      assign free_w[gi]  = ~valid_reg | ready_w[gi];
      assign load_w[gi]  = accept_w & (sel == (gi == 1));

      // Next state: a load overrides a drain, so drain+load keeps valid high
      // and sustains one word per cycle. Drain alone clears valid, data holds.
      always_comb begin
        q_next     = q_reg;
        valid_next = valid_reg;
        cnt_next   = cnt_reg;
        if (load_w[gi]) begin
          q_next     = d;
          valid_next = 1'b1;
          cnt_next   = cnt_reg + 1'b1;
        end else if (ready_w[gi]) begin
          valid_next = 1'b0;
        end
      end

      // Channel registers; reset discards any word still held.
      always_ff @(posedge clk) begin
        if (reset) begin
          q_reg     <= '0;
          valid_reg <= 1'b0;
          cnt_reg   <= '0;
        end else begin
          q_reg     <= q_next;
          valid_reg <= valid_next;
          cnt_reg   <= cnt_next;
        end
      end
    end
  endgenerate

  assign q0       = g_ch[0].q_reg;
  assign q1       = g_ch[1].q_reg;
  assign q0_valid = valid_w[0];
  assign q1_valid = valid_w[1];
  assign cnt0     = g_ch[0].cnt_reg;
  assign cnt1     = g_ch[1].cnt_reg;

endmodule

// File: tb/tb_demux_stream.sv
// Bench for demux_stream: a directed vector table, a counter-wrap sequence on
// a narrow-counter instance, and a randomized scoreboard run.
module tb_demux_stream;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance (N=8, CW=16)
  logic        reset, sel, d_valid, d_ready, q0_valid, q0_ready, q1_valid, q1_ready;
  logic [7:0]  d, q0, q1;
  logic [15:0] cnt0, cnt1;

  demux_stream #(.N(8), .CW(16)) dut (
    .clk(clk), .reset(reset), .sel(sel), .d(d), .d_valid(d_valid), .d_ready(d_ready),
    .q0(q0), .q0_valid(q0_valid), .q0_ready(q0_ready),
    .q1(q1), .q1_valid(q1_valid), .q1_ready(q1_ready),
    .cnt0(cnt0), .cnt1(cnt1)
  );

  // Narrow-counter instance for the wrap test (CW=4)
  logic        w_reset, w_sel, w_d_valid, w_d_ready, w_q0_valid, w_q0_ready, w_q1_valid, w_q1_ready;
  logic [7:0]  w_d, w_q0, w_q1;
  logic [3:0]  w_cnt0, w_cnt1;

  demux_stream #(.N(8), .CW(4)) dut_w (
    .clk(clk), .reset(w_reset), .sel(w_sel), .d(w_d), .d_valid(w_d_valid), .d_ready(w_d_ready),
    .q0(w_q0), .q0_valid(w_q0_valid), .q0_ready(w_q0_ready),
    .q1(w_q1), .q1_valid(w_q1_valid), .q1_ready(w_q1_ready),
    .cnt0(w_cnt0), .cnt1(w_cnt1)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic       rst;
    logic       dv;
    logic       s;
    logic [7:0] dd;
    logic       r0;
    logic       r1;
    logic       rdy;   // expected d_ready before the edge
    logic [7:0] e_q0;
    logic       e_v0;
    logic [7:0] e_q1;
    logic       e_v1;
    logic [15:0] e_c0;
    logic [15:0] e_c1;
  } vec_t;

  vec_t tbl [18];

  logic [7:0] sb0 [$];
  logic [7:0] sb1 [$];
  int         acc0, acc1;
  logic       exp_rdy;

  initial begin
    //            rst dv  s   d      r0  r1  rdy  q0     v0  q1     v1  c0  c1
    // reset, then one word to channel 0 with its consumer stalled
    tbl[0]  = '{1'b1,1'b0,1'b0,8'h00,1'b0,1'b0,1'b0,8'h00,1'b0,8'h00,1'b0,16'd0,16'd0};
    tbl[1]  = '{1'b0,1'b1,1'b0,8'hA5,1'b0,1'b0,1'b1,8'hA5,1'b1,8'h00,1'b0,16'd1,16'd0};
    tbl[2]  = '{1'b0,1'b0,1'b0,8'h00,1'b0,1'b0,1'b0,8'hA5,1'b1,8'h00,1'b0,16'd1,16'd0};
    tbl[3]  = '{1'b0,1'b0,1'b1,8'h00,1'b0,1'b0,1'b1,8'hA5,1'b1,8'h00,1'b0,16'd1,16'd0};
    // channel 0 full: stall, then drain+load in the same cycle, then plain drain
    tbl[4]  = '{1'b0,1'b1,1'b0,8'h3C,1'b0,1'b0,1'b0,8'hA5,1'b1,8'h00,1'b0,16'd1,16'd0};
    tbl[5]  = '{1'b0,1'b1,1'b0,8'h3C,1'b1,1'b0,1'b1,8'h3C,1'b1,8'h00,1'b0,16'd2,16'd0};
    tbl[6]  = '{1'b0,1'b0,1'b0,8'h00,1'b1,1'b0,1'b1,8'h3C,1'b0,8'h00,1'b0,16'd2,16'd0};
    // fill both channels, then reset (d_ready must be 0 even though ch0 is free)
    tbl[7]  = '{1'b0,1'b1,1'b1,8'h77,1'b0,1'b0,1'b1,8'h3C,1'b0,8'h77,1'b1,16'd2,16'd1};
    tbl[8]  = '{1'b0,1'b1,1'b0,8'h88,1'b0,1'b0,1'b1,8'h88,1'b1,8'h77,1'b1,16'd3,16'd1};
    tbl[9]  = '{1'b1,1'b1,1'b0,8'h99,1'b1,1'b0,1'b0,8'h00,1'b0,8'h00,1'b0,16'd0,16'd0};
    // alternating sel with both consumers ready
    tbl[10] = '{1'b0,1'b1,1'b0,8'h01,1'b1,1'b1,1'b1,8'h01,1'b1,8'h00,1'b0,16'd1,16'd0};
    tbl[11] = '{1'b0,1'b1,1'b1,8'h02,1'b1,1'b1,1'b1,8'h01,1'b0,8'h02,1'b1,16'd1,16'd1};
    tbl[12] = '{1'b0,1'b1,1'b0,8'h03,1'b1,1'b1,1'b1,8'h03,1'b1,8'h02,1'b0,16'd2,16'd1};
    tbl[13] = '{1'b0,1'b1,1'b1,8'h04,1'b1,1'b1,1'b1,8'h03,1'b0,8'h04,1'b1,16'd2,16'd2};
    tbl[14] = '{1'b0,1'b0,1'b0,8'h00,1'b1,1'b1,1'b1,8'h03,1'b0,8'h04,1'b0,16'd2,16'd2};
    // channel 1: load, sustained drain+load, then stall
    tbl[15] = '{1'b0,1'b1,1'b1,8'h05,1'b0,1'b0,1'b1,8'h03,1'b0,8'h05,1'b1,16'd2,16'd3};
    tbl[16] = '{1'b0,1'b1,1'b1,8'h06,1'b0,1'b1,1'b1,8'h03,1'b0,8'h06,1'b1,16'd2,16'd4};
    tbl[17] = '{1'b0,1'b1,1'b1,8'h07,1'b0,1'b0,1'b0,8'h03,1'b0,8'h06,1'b1,16'd2,16'd4};

    reset = 1'b1; sel = 1'b0; d = '0; d_valid = 1'b0; q0_ready = 1'b0; q1_ready = 1'b0;
    w_reset = 1'b1; w_sel = 1'b0; w_d = '0; w_d_valid = 1'b0; w_q0_ready = 1'b0; w_q1_ready = 1'b0;

    // ---- directed vector table ----
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      reset = tbl[i].rst; d_valid = tbl[i].dv; sel = tbl[i].s; d = tbl[i].dd;
      q0_ready = tbl[i].r0; q1_ready = tbl[i].r1;
      #1;
      chk($sformatf("vec%0d d_ready", i), 32'(d_ready), 32'(tbl[i].rdy));
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d q0", i),       32'(q0),       32'(tbl[i].e_q0));
      chk($sformatf("vec%0d q0_valid", i), 32'(q0_valid), 32'(tbl[i].e_v0));
      chk($sformatf("vec%0d q1", i),       32'(q1),       32'(tbl[i].e_q1));
      chk($sformatf("vec%0d q1_valid", i), 32'(q1_valid), 32'(tbl[i].e_v1));
      chk($sformatf("vec%0d cnt0", i),     32'(cnt0),     32'(tbl[i].e_c0));
      chk($sformatf("vec%0d cnt1", i),     32'(cnt1),     32'(tbl[i].e_c1));
      $display("vec %0d: rst=%0d dv=%0d sel=%0d d=%h -> q0=%h/%0d q1=%h/%0d cnt0=%0d cnt1=%0d",
               i, reset, d_valid, sel, d, q0, q0_valid, q1, q1_valid, cnt0, cnt1);
    end

    // ---- counter wrap on the CW=4 instance: 17 words to channel 1 ----
    @(negedge clk);
    w_reset = 1'b0; w_d_valid = 1'b1; w_sel = 1'b1; w_q1_ready = 1'b1;
    for (int i = 0; i < 17; i++) begin
      w_d = 8'(i + 1);
      #1;
      chk($sformatf("wrap%0d d_ready", i), 32'(w_d_ready), 32'd1);
      @(posedge clk);
      #1;
      chk($sformatf("wrap%0d q1", i),   32'(w_q1),   32'(i + 1));
      chk($sformatf("wrap%0d cnt0", i), 32'(w_cnt0), 32'd0);
      if (i == 14) chk("wrap cnt1 at 15 words", 32'(w_cnt1), 32'd15);
      if (i == 15) chk("wrap cnt1 at 16 words", 32'(w_cnt1), 32'd0);
      if (i == 16) chk("wrap cnt1 at 17 words", 32'(w_cnt1), 32'd1);
      $display("wrap %0d: d=%h q1=%h cnt1=%0d cnt0=%0d", i, w_d, w_q1, w_cnt1, w_cnt0);
      @(negedge clk);
    end
    w_d_valid = 1'b0;

    // ---- random traffic against a per-channel scoreboard ----
    reset = 1'b1; d_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    acc0 = 0; acc1 = 0;
    for (int c = 0; c < 10000; c++) begin
      @(negedge clk);
      d_valid  = 1'($urandom_range(0, 1));
      sel      = 1'($urandom_range(0, 1));
      d        = 8'($urandom);
      q0_ready = ($urandom_range(0, 3) != 0);
      q1_ready = ($urandom_range(0, 3) != 0);
      #1;
      exp_rdy = sel ? (!q1_valid || q1_ready) : (!q0_valid || q0_ready);
      chk("rnd d_ready", 32'(d_ready), 32'(exp_rdy));
      if (q0_valid && q0_ready && sb0.size() > 0) chk("rnd q0 order", 32'(q0), 32'(sb0.pop_front()));
      if (q1_valid && q1_ready && sb1.size() > 0) chk("rnd q1 order", 32'(q1), 32'(sb1.pop_front()));
      if (d_valid && exp_rdy) begin
        if (sel) begin sb1.push_back(d); acc1++; end
        else     begin sb0.push_back(d); acc0++; end
      end
      @(posedge clk);
      #1;
      chk("rnd q0 occupancy", 32'(q0_valid), 32'(sb0.size()));
      chk("rnd q1 occupancy", 32'(q1_valid), 32'(sb1.size()));
      if (sb0.size() > 0) chk("rnd q0 data", 32'(q0), 32'(sb0[0]));
      if (sb1.size() > 0) chk("rnd q1 data", 32'(q1), 32'(sb1[0]));
      chk("rnd cnt0", 32'(cnt0), 32'(acc0[15:0]));
      chk("rnd cnt1", 32'(cnt1), 32'(acc1[15:0]));
    end
    $display("random run: %0d words to ch0, %0d words to ch1", acc0, acc1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
